// File: rtl/mem_arbiter_if.sv
// Bundle of every handshake/bus signal around the memory arbiter: the fetch
// port, the data port and the single-port memory request/response channel.
// The master view belongs to the arbiter (it masters the memory bus); the
// slave view is everything around it (pipeline stages and memory).
interface mem_arbiter_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    // Fetch port
    logic                    if_req;
    logic [ADDR_WIDTH-1:0]   if_addr;
    logic                    flush;
    logic [DATA_WIDTH-1:0]   if_rdata;
    logic                    if_rvalid;
    logic                    if_stall;

    // Data port
    logic                    dm_req;
    logic                    dm_we;
    logic [DATA_WIDTH/8-1:0] dm_be;
    logic [ADDR_WIDTH-1:0]   dm_addr;
    logic [DATA_WIDTH-1:0]   dm_wdata;
    logic [DATA_WIDTH-1:0]   dm_rdata;
    logic                    dm_rvalid;
    logic                    dm_stall;

    // Memory port
    logic                    mem_req;
    logic                    mem_we;
    logic [DATA_WIDTH/8-1:0] mem_be;
    logic [ADDR_WIDTH-1:0]   mem_addr;
    logic [DATA_WIDTH-1:0]   mem_wdata;
    logic                    mem_gnt;
    logic                    mem_rvalid;
    logic [DATA_WIDTH-1:0]   mem_rdata;

    modport master (
        input  if_req, if_addr, flush,
        input  dm_req, dm_we, dm_be, dm_addr, dm_wdata,
        input  mem_gnt, mem_rvalid, mem_rdata,
        output if_rdata, if_rvalid, if_stall,
        output dm_rdata, dm_rvalid, dm_stall,
        output mem_req, mem_we, mem_be, mem_addr, mem_wdata
    );

    modport slave (
        output if_req, if_addr, flush,
        output dm_req, dm_we, dm_be, dm_addr, dm_wdata,
        output mem_gnt, mem_rvalid, mem_rdata,
        input  if_rdata, if_rvalid, if_stall,
        input  dm_rdata, dm_rvalid, dm_stall,
        input  mem_req, mem_we, mem_be, mem_addr, mem_wdata
    );
endinterface

// File: rtl/mem_arbiter.sv
// Arbiter sharing one single-port memory between instruction fetch and the
// memory stage. One transaction is outstanding at a time; the data port wins
// ties, but a run counter hands the memory to fetch after MAX_DATA_RUN data
// grants made while fetch was waiting. Fetches squashed by a taken branch
// still finish on the memory side, their result is simply discarded.
module mem_arbiter #(
    parameter int ADDR_WIDTH   = 32,
    parameter int DATA_WIDTH   = 32,
    parameter int MAX_DATA_RUN = 4
) (
    input  logic          clk,
    input  logic          rst,
    mem_arbiter_if.master bus
);
    localparam int RUN_WIDTH = $clog2(MAX_DATA_RUN + 1);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT,
        RESP
    } state_t;

    state_t               state;
    logic                 owner_dm;
    logic                 drop;
    logic [RUN_WIDTH-1:0] run;
    logic                 grant_dm;
    logic                 grant_if;

    // Arbitration decision used in IDLE: data first unless its run has starved fetch
    always_comb begin
        grant_dm = bus.dm_req && (!bus.if_req || (run < RUN_WIDTH'(MAX_DATA_RUN)));
        grant_if = !grant_dm && bus.if_req;
    end

    // A stage stalls while it is requesting and its completion pulse is not present
    assign bus.if_stall = bus.if_req & ~bus.if_rvalid;
    assign bus.dm_stall = bus.dm_req & ~bus.dm_rvalid;

    // Transaction FSM with registered memory request fields and response outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            owner_dm      <= 1'b0;
            drop          <= 1'b0;
            run           <= '0;
            bus.mem_req   <= 1'b0;
            bus.mem_we    <= 1'b0;
            bus.mem_be    <= '0;
            bus.mem_addr  <= '0;
            bus.mem_wdata <= '0;
            bus.if_rvalid <= 1'b0;
            bus.dm_rvalid <= 1'b0;
            bus.if_rdata  <= '0;
            bus.dm_rdata  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    bus.if_rvalid <= 1'b0;
                    bus.dm_rvalid <= 1'b0;
                    if (grant_dm) begin
                        owner_dm      <= 1'b1;
                        drop          <= 1'b0;
                        run           <= bus.if_req ? run + 1'b1 : '0;
                        bus.mem_req   <= 1'b1;
                        bus.mem_we    <= bus.dm_we;
                        bus.mem_be    <= bus.dm_be;
                        bus.mem_addr  <= bus.dm_addr;
                        bus.mem_wdata <= bus.dm_wdata;
                        state         <= REQ;
                    end else if (grant_if) begin
                        owner_dm      <= 1'b0;
                        drop          <= bus.flush;
                        run           <= '0;
                        bus.mem_req   <= 1'b1;
                        bus.mem_we    <= 1'b0;
                        bus.mem_be    <= '1;
                        bus.mem_addr  <= bus.if_addr;
                        bus.mem_wdata <= '0;
                        state         <= REQ;
                    end
                end
                REQ: begin
                    if (!owner_dm && bus.flush) begin
                        drop <= 1'b1;
                    end
                    if (bus.mem_gnt) begin
                        bus.mem_req <= 1'b0;
                        state       <= WAIT;
                    end
                end
                WAIT: begin
                    if (!owner_dm && bus.flush) begin
                        drop <= 1'b1;
                    end
                    if (bus.mem_rvalid) begin
                        state <= RESP;
                        if (owner_dm) begin
                            bus.dm_rvalid <= 1'b1;
                            if (!bus.mem_we) begin
                                bus.dm_rdata <= bus.mem_rdata;
                            end
                        end else if (!(drop || bus.flush)) begin
                            bus.if_rvalid <= 1'b1;
                            bus.if_rdata  <= bus.mem_rdata;
                        end
                    end
                end
                RESP: begin
                    bus.if_rvalid <= 1'b0;
                    bus.dm_rvalid <= 1'b0;
                    state         <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios, a simple memory
// responder with adjustable grant/response delays, and a transaction-level
// model that predicts every output cycle by cycle.
module tb_mem_arbiter;
    localparam int AW      = 32;
    localparam int DW      = 32;
    localparam int MAX_RUN = 2;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    mem_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    mem_arbiter #(
        .ADDR_WIDTH  (AW),
        .DATA_WIDTH  (DW),
        .MAX_DATA_RUN(MAX_RUN)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int checks = 0;
    int passes = 0;
    int cyc    = 0;

    // Memory contents and responder knobs
    logic [31:0] mem_model [logic [31:0]];
    int          gnt_delay = 0;
    int          rsp_delay = 0;
    int          gnt_cnt   = 0;
    int          rsp_cnt   = 0;
    logic        rsp_armed = 1'b0;
    logic [31:0] rsp_data  = 32'h0;

    // Model state
    logic        m_valid    = 1'b0;
    logic        m_busy     = 1'b0;
    logic        m_accepted = 1'b0;
    logic        m_retiring = 1'b0;
    logic        m_owner_dm = 1'b0;
    logic        m_drop     = 1'b0;
    logic        m_fields   = 1'b0;
    int          m_run      = 0;
    logic        exp_mem_req, exp_mem_we, exp_if_rvalid, exp_dm_rvalid;
    logic [3:0]  exp_mem_be;
    logic [31:0] exp_mem_addr, exp_mem_wdata, exp_if_rdata, exp_dm_rdata;
    bit          grant_log [$];

    // Cycle counter used for latency measurements
    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual === expected) passes++;
        else $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, actual, expected, cyc);
    endtask

    task automatic applyStimulus(input logic ifr, input logic [31:0] ia, input logic drq, input logic we,
                                 input logic [3:0] be, input logic [31:0] da, input logic [31:0] wd);
        bus.if_req   = ifr;
        bus.if_addr  = ia;
        bus.dm_req   = drq;
        bus.dm_we    = we;
        bus.dm_be    = be;
        bus.dm_addr  = da;
        bus.dm_wdata = wd;
    endtask

    // sel: 0 = if_rvalid, 1 = dm_rvalid, otherwise mem_req
    task automatic waitEvent(input int sel, input string name);
        bit seen = 0;
        for (int n = 0; n < 40 && !seen; n++) begin
            @(negedge clk);
            case (sel)
                0:       seen = bus.if_rvalid;
                1:       seen = bus.dm_rvalid;
                default: seen = bus.mem_req;
            endcase
        end
        if (!seen) begin
            checks++;
            $display("[TB] FAIL %s: event not seen, got none within 40 cycles, expected one", name);
        end
    endtask

    // Memory responder: grants after gnt_delay cycles, answers rsp_delay cycles later
    initial begin
        bus.mem_gnt    = 1'b0;
        bus.mem_rvalid = 1'b0;
        bus.mem_rdata  = 32'h0;
        forever begin
            @(posedge clk);
            #1;
            bus.mem_gnt    = 1'b0;
            bus.mem_rvalid = 1'b0;
            if (rsp_armed) begin
                if (rsp_cnt == 0) begin
                    bus.mem_rvalid = 1'b1;
                    bus.mem_rdata  = rsp_data;
                    rsp_armed      = 1'b0;
                end else begin
                    rsp_cnt--;
                end
            end
            if (bus.mem_req) begin
                if (gnt_cnt >= gnt_delay) begin
                    logic [31:0] cur;
                    bus.mem_gnt = 1'b1;
                    gnt_cnt     = 0;
                    cur = mem_model.exists(bus.mem_addr) ? mem_model[bus.mem_addr] : (bus.mem_addr ^ 32'hA5A5_0000);
                    if (bus.mem_we) begin
                        for (int b = 0; b < 4; b++)
                            if (bus.mem_be[b]) cur[8*b +: 8] = bus.mem_wdata[8*b +: 8];
                        mem_model[bus.mem_addr] = cur;
                        rsp_data = 32'hBAD0_0000;
                    end else begin
                        rsp_data = cur;
                    end
                    rsp_armed = 1'b1;
                    rsp_cnt   = rsp_delay;
                end else begin
                    gnt_cnt++;
                end
            end
        end
    end

    // Compare DUT outputs with the model's prediction, then advance the model one cycle
    always @(negedge clk) begin
        if (m_valid) begin
            checkOutput("if_rvalid", bus.if_rvalid, exp_if_rvalid);
            checkOutput("dm_rvalid", bus.dm_rvalid, exp_dm_rvalid);
            checkOutput("if_rdata", bus.if_rdata, exp_if_rdata);
            checkOutput("dm_rdata", bus.dm_rdata, exp_dm_rdata);
            checkOutput("mem_req", bus.mem_req, exp_mem_req);
            checkOutput("if_stall", bus.if_stall, bus.if_req & ~exp_if_rvalid);
            checkOutput("dm_stall", bus.dm_stall, bus.dm_req & ~exp_dm_rvalid);
            if (m_fields) begin
                checkOutput("mem_addr", bus.mem_addr, exp_mem_addr);
                checkOutput("mem_we", bus.mem_we, exp_mem_we);
                checkOutput("mem_be", bus.mem_be, exp_mem_be);
                checkOutput("mem_wdata", bus.mem_wdata, exp_mem_wdata);
            end
        end
        if (rst) begin
            m_valid = 1'b1; m_busy = 1'b0; m_accepted = 1'b0; m_retiring = 1'b0;
            m_drop = 1'b0; m_run = 0; m_fields = 1'b1;
            exp_mem_req = 1'b0; exp_mem_we = 1'b0; exp_mem_be = 4'h0;
            exp_mem_addr = 32'h0; exp_mem_wdata = 32'h0;
            exp_if_rvalid = 1'b0; exp_dm_rvalid = 1'b0;
            exp_if_rdata = 32'h0; exp_dm_rdata = 32'h0;
        end else if (m_valid) begin
            if (m_retiring) begin
                m_retiring = 1'b0;
                m_fields = 1'b0;
                exp_if_rvalid = 1'b0;
                exp_dm_rvalid = 1'b0;
            end else if (!m_busy) begin
                logic g_dm, g_if;
                m_fields = 1'b0;
                g_dm = bus.dm_req && (!bus.if_req || m_run < MAX_RUN);
                g_if = !g_dm && bus.if_req;
                if (g_dm || g_if) begin
                    grant_log.push_back(g_dm);
                    m_busy = 1'b1; m_accepted = 1'b0; m_fields = 1'b1;
                    m_owner_dm = g_dm;
                    m_drop = g_if && bus.flush;
                    m_run = (g_dm && bus.if_req) ? m_run + 1 : 0;
                    exp_mem_req   = 1'b1;
                    exp_mem_addr  = g_dm ? bus.dm_addr : bus.if_addr;
                    exp_mem_we    = g_dm ? bus.dm_we : 1'b0;
                    exp_mem_be    = g_dm ? bus.dm_be : 4'hF;
                    exp_mem_wdata = g_dm ? bus.dm_wdata : 32'h0;
                end
            end else begin
                if (!m_owner_dm && bus.flush) m_drop = 1'b1;
                if (!m_accepted) begin
                    if (bus.mem_gnt) begin
                        m_accepted = 1'b1;
                        exp_mem_req = 1'b0;
                        m_fields = 1'b0;
                    end
                end else if (bus.mem_rvalid) begin
                    m_busy = 1'b0;
                    m_retiring = 1'b1;
                    if (m_owner_dm) begin
                        exp_dm_rvalid = 1'b1;
                        if (!exp_mem_we) exp_dm_rdata = bus.mem_rdata;
                    end else if (!m_drop) begin
                        exp_if_rvalid = 1'b1;
                        exp_if_rdata = bus.mem_rdata;
                    end
                end
            end
        end
    end

    // Safety net so the run always ends
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation still running, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    // Directed scenarios
    initial begin
        int c0;
        int pulses;
        bit exp_order [6];
        exp_order = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};

        mem_model[32'h100]  = 32'h0050_0093;
        mem_model[32'h104]  = 32'h00A0_0113;
        mem_model[32'h200]  = 32'h1111_2222;
        mem_model[32'h300]  = 32'h3333_4444;
        mem_model[32'h2000] = 32'h1234_5678;
        mem_model[32'h40]   = 32'hAAAA_5555;

        rst = 1'b1;
        bus.flush = 1'b0;
        applyStimulus(0, 32'h0, 0, 0, 4'h0, 32'h0, 32'h0);
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        checkOutput("reset mem_req", bus.mem_req, 32'h0);
        checkOutput("reset if_rdata", bus.if_rdata, 32'h0);
        checkOutput("reset if_stall", bus.if_stall, 32'h0);

        $display("[TB] fetch");
        @(posedge clk); #1;
        c0 = cyc; gnt_delay = 0; rsp_delay = 1;
        applyStimulus(1, 32'h100, 0, 0, 4'h0, 32'h0, 32'h0);
        waitEvent(2, "fetch mem_req");
        checkOutput("fetch req cycle", 32'(cyc - c0), 32'd1);
        checkOutput("fetch mem_addr", bus.mem_addr, 32'h100);
        waitEvent(0, "fetch if_rvalid");
        checkOutput("fetch latency", 32'(cyc - c0), 32'd4);
        checkOutput("fetch if_rdata", bus.if_rdata, 32'h0050_0093);
        checkOutput("fetch if_stall at pulse", bus.if_stall, 32'h0);
        @(posedge clk); #1;
        applyStimulus(0, 32'h0, 0, 0, 4'h0, 32'h0, 32'h0);

        $display("[TB] contention");
        @(posedge clk); #1;
        rsp_delay = 0; grant_log.delete();
        applyStimulus(1, 32'h104, 1, 0, 4'hF, 32'h2000, 32'h0);
        waitEvent(1, "contention dm_rvalid");
        checkOutput("contention dm_rdata", bus.dm_rdata, 32'h1234_5678);
        checkOutput("contention if still stalled", bus.if_stall, 32'h1);
        @(posedge clk); #1;
        applyStimulus(1, 32'h104, 0, 0, 4'h0, 32'h0, 32'h0);
        waitEvent(2, "contention IF mem_req");
        checkOutput("contention IF mem_addr", bus.mem_addr, 32'h104);
        waitEvent(0, "contention if_rvalid");
        checkOutput("contention if_rdata", bus.if_rdata, 32'h00A0_0113);
        @(posedge clk); #1;
        applyStimulus(0, 32'h0, 0, 0, 4'h0, 32'h0, 32'h0);

        $display("[TB] store");
        @(posedge clk); #1;
        gnt_delay = 1; rsp_delay = 1;
        applyStimulus(0, 32'h0, 1, 1, 4'b0011, 32'h40, 32'hDEAD_BEEF);
        waitEvent(2, "store mem_req");
        @(negedge clk);
        checkOutput("store mem_req held", bus.mem_req, 32'h1);
        checkOutput("store mem_we", bus.mem_we, 32'h1);
        checkOutput("store mem_be", bus.mem_be, 32'h3);
        checkOutput("store mem_wdata", bus.mem_wdata, 32'hDEAD_BEEF);
        waitEvent(1, "store dm_rvalid");
        checkOutput("store dm_rdata kept", bus.dm_rdata, 32'h1234_5678);
        @(posedge clk); #1;
        gnt_delay = 0;
        applyStimulus(0, 32'h0, 0, 0, 4'h0, 32'h0, 32'h0);

        $display("[TB] starvation");
        @(posedge clk); #1;
        rsp_delay = 0; grant_log.delete();
        applyStimulus(1, 32'h100, 1, 0, 4'hF, 32'h40, 32'h0);
        begin
            bit done = 0;
            for (int n = 0; n < 100 && !done; n++) begin
                @(negedge clk);
                done = (grant_log.size() >= 6) && bus.if_rvalid;
            end
            if (!done) begin
                checks++;
                $display("[TB] FAIL starvation: six grants not seen, got %0d, expected 6", grant_log.size());
            end
        end
        @(posedge clk); #1;
        applyStimulus(0, 32'h0, 0, 0, 4'h0, 32'h0, 32'h0);
        for (int i = 0; i < 6; i++)
            checkOutput($sformatf("starvation grant %0d is DM", i), 32'(grant_log[i]), 32'(exp_order[i]));
        checkOutput("starvation dm_rdata merged", bus.dm_rdata, 32'hAAAA_BEEF);
        checkOutput("starvation if_rdata", bus.if_rdata, 32'h0050_0093);

        $display("[TB] flush");
        @(posedge clk); #1;
        rsp_delay = 2;
        applyStimulus(1, 32'h200, 0, 0, 4'h0, 32'h0, 32'h0);
        waitEvent(2, "flush mem_req");
        @(posedge clk); #1;
        bus.flush = 1'b1;
        applyStimulus(0, 32'h0, 0, 0, 4'h0, 32'h0, 32'h0);
        @(posedge clk); #1;
        bus.flush = 1'b0;
        pulses = 0;
        repeat (8) begin
            @(negedge clk);
            if (bus.if_rvalid) pulses++;
        end
        checkOutput("flush pulses", 32'(pulses), 32'd0);
        checkOutput("flush if_rdata kept", bus.if_rdata, 32'h0050_0093);
        @(posedge clk); #1;
        rsp_delay = 0;
        applyStimulus(1, 32'h300, 0, 0, 4'h0, 32'h0, 32'h0);
        waitEvent(0, "post-flush if_rvalid");
        checkOutput("post-flush if_rdata", bus.if_rdata, 32'h3333_4444);
        @(posedge clk); #1;
        applyStimulus(0, 32'h0, 0, 0, 4'h0, 32'h0, 32'h0);

        $display("[TB] reset mid-transaction");
        @(posedge clk); #1;
        rsp_delay = 4;
        applyStimulus(1, 32'h100, 0, 0, 4'h0, 32'h0, 32'h0);
        waitEvent(2, "reset-test mem_req");
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        applyStimulus(0, 32'h0, 0, 0, 4'h0, 32'h0, 32'h0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        checkOutput("after reset mem_req", bus.mem_req, 32'h0);
        checkOutput("after reset if_rdata", bus.if_rdata, 32'h0);
        checkOutput("after reset dm_rdata", bus.dm_rdata, 32'h0);
        pulses = 0;
        repeat (8) begin
            @(negedge clk);
            if (bus.if_rvalid || bus.dm_rvalid) pulses++;
        end
        checkOutput("late rvalid pulses", 32'(pulses), 32'd0);
        @(posedge clk); #1;
        c0 = cyc; rsp_delay = 0;
        applyStimulus(1, 32'h100, 0, 0, 4'h0, 32'h0, 32'h0);
        waitEvent(0, "fresh fetch if_rvalid");
        checkOutput("fresh fetch latency", 32'(cyc - c0), 32'd3);
        checkOutput("fresh fetch if_rdata", bus.if_rdata, 32'h0050_0093);
        @(posedge clk); #1;
        applyStimulus(0, 32'h0, 0, 0, 4'h0, 32'h0, 32'h0);
        repeat (3) @(posedge clk);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
Shares one single-port unified memory between the instruction fetch stage and the memory stage of the 5-stage pipeline. The FSM has one outstanding transaction at a time. The data port has priority, with a starvation guard that forces an instruction grant after a run of data grants. The block produces per-port stall signals for the pipeline registers and drops fetch responses squashed by a taken branch.

Parameters:
ADDR_WIDTH, 32, address width of all ports
DATA_WIDTH, 32, data width of all ports
MAX_DATA_RUN, 4, max consecutive data grants while if_req is pending (>=1)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
if_req  in  1  fetch request, level, held until if_rvalid
if_addr  in  ADDR_WIDTH  fetch address
flush  in  1  taken branch; squash the fetch in flight
if_rdata  out  DATA_WIDTH  fetched instruction
if_rvalid  out  1  one-cycle fetch completion pulse
if_stall  out  1  fetch stage must hold
dm_req  in  1  data request, level, held until dm_rvalid
dm_we  in  1  1 = store
dm_be  in  DATA_WIDTH/8  byte enables
dm_addr  in  ADDR_WIDTH  data address
dm_wdata  in  DATA_WIDTH  store data
dm_rdata  out  DATA_WIDTH  load data
dm_rvalid  out  1  one-cycle data completion pulse (loads and stores)
dm_stall  out  1  memory stage must hold
mem_req  out  1  memory request, held until mem_gnt
mem_we  out  1  store
mem_be  out  DATA_WIDTH/8  byte enables
mem_addr  out  ADDR_WIDTH  address
mem_wdata  out  DATA_WIDTH  store data
mem_gnt  in  1  memory accepted request (sampled while mem_req=1)
mem_rvalid  in  1  memory response, including store acks
mem_rdata  in  DATA_WIDTH  read data

Behaviour:
- States: IDLE, REQ, WAIT, RESP. Registers: owner (IF/DM), drop, run counter, latched request fields.
- IDLE, arbitration:
  - If dm_req and (!if_req or run < MAX_DATA_RUN): grant DM. Run increments if if_req is pending, otherwise clears to 0.
  - Else if if_req: grant IF and clear run.
  - On a grant, latch addr/we/be/wdata (IF grant forces we=0, be=all ones), go to REQ. drop <= flush if owner is IF.
- REQ: mem_req=1 with latched fields. On mem_gnt go to WAIT. Fields stay stable until gnt.
- WAIT: mem_req=0. On mem_rvalid, register mem_rdata into the owner's rdata register and go to RESP.
- RESP: pulse the owner's rvalid for exactly one cycle, unless owner=IF and drop=1 (then no pulse). Go to IDLE. No arbitration happens in RESP, so a requester's still-high req is not re-granted.
- flush:
  - Sets drop whenever owner=IF in REQ or WAIT.
  - The memory transaction is never aborted; it completes and its result is discarded.
  - flush has no effect on a DM-owned transaction.
- Timing: minimum latency from req to rvalid is 3 cycles (grant, gnt in REQ, rvalid in WAIT, pulse in RESP). Each wait cycle of gnt or rvalid adds one cycle.
- Stalls (combinational):
  - if_stall = if_req & !if_rvalid.
  - dm_stall = dm_req & !dm_rvalid.
- Read data:
  - if_rdata and dm_rdata hold their last value between pulses.
  - dm_rdata is not updated by stores.
- mem_rvalid outside WAIT is ignored. mem_gnt outside REQ is ignored.
- Reset (any state, including mid-transaction):
  - State IDLE.
  - All outputs 0: mem_req, mem_we, mem_be, mem_addr, mem_wdata, both rvalids, both rdatas.
  - run=0, drop=0.
  - Stalls follow their equations.

Test Plan:
- Fetch: if_req=1, if_addr=0x100 at c0; mem_gnt immediate; mem_rvalid at c3 with 0x00500093 -> mem_req=1 at c1, mem_addr=0x100; if_rvalid=1 at c4 with if_rdata=0x00500093; if_stall=1 c0..c3, 0 at c4.
- Contention: if_req and dm_req (load 0x2000) raised together -> DM is served first and dm_rvalid pulses. The IF grant follows in the IDLE after RESP, with mem_addr=IF address. Run=1, so the guard does not trigger.
- Starvation with MAX_DATA_RUN=2: if_req held high and dm_req re-asserted after each dm_rvalid -> grant order DM, DM, IF, DM, DM, IF.
- Store: dm_we=1, dm_be=4'b0011, dm_addr=0x40, dm_wdata=0xDEADBEEF -> mem_we=1, mem_be=0011, mem_wdata=0xDEADBEEF during REQ; dm_rvalid pulses after the ack; dm_rdata unchanged.
- Flush: flush pulsed in WAIT of an IF fetch to 0x200 -> transaction still completes; no if_rvalid pulse; if_rdata unchanged; FSM returns to IDLE. The next if_req (0x300) is served normally.
- Reset mid-WAIT: rst=1 for one cycle -> all outputs 0 and state IDLE. A late mem_rvalid produces no rvalid pulse. A fresh fetch then completes with nominal 3-cycle latency.
